dram_port_arbiter: RTL and testbench

//  Shares the single MIG-style DDR user port between the sample write path (packer chunks) and the

---
 rtl/dram_if_pkg.sv | 6 +
 rtl/dram_port_arbiter_if.sv | 33 +++
 rtl/dram_rd_tracker.sv | 37 +++
 rtl/dram_port_arbiter.sv | 79 +++++++
 tb/tb_dram_port_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dram_if_pkg.sv
// dram_if_pkg: DDR user-port command codes and arbiter state encoding
package dram_if_pkg;
  localparam logic [2:0] DDR_CMD_WRITE = 3'b000;
  localparam logic [2:0] DDR_CMD_READ  = 3'b001;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} arb_state_t;
endpackage

// File: rtl/dram_port_arbiter_if.sv
// dram_port_arbiter_if: client write/read handshakes plus the MIG-style DDR user port
interface dram_port_arbiter_if #(
  parameter int MEM_IF_WIDTH = 128,
  parameter int ADX_WIDTH    = 27
) ();
  logic                    wr_req;
  logic [ADX_WIDTH-1:0]    wr_addr;
  logic [MEM_IF_WIDTH-1:0] wr_data;
  logic                    wr_ack;
  logic                    rd_req;
  logic [ADX_WIDTH-1:0]    rd_addr;
  logic                    rd_ack;
  logic [MEM_IF_WIDTH-1:0] rd_data;
  logic                    rd_valid;
  logic                    app_en;
  logic [2:0]              app_cmd;
  logic [ADX_WIDTH-1:0]    app_addr;
  logic                    app_rdy;
  logic [MEM_IF_WIDTH-1:0] app_wdf_data;
  logic                    app_wdf_wren;
  logic                    app_wdf_end;
  logic                    app_wdf_rdy;
  logic [MEM_IF_WIDTH-1:0] app_rd_data;
  logic                    app_rd_data_valid;
  modport master (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output wr_ack, rd_ack, rd_data, rd_valid, app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end
  );
  modport slave (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  wr_ack, rd_ack, rd_data, rd_valid, app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/dram_rd_tracker.sv
// dram_rd_tracker: outstanding-read counter, registered read return and unexpected-return flag
module dram_rd_tracker #(
  parameter int MEM_IF_WIDTH       = 128,
  parameter int MAX_RD_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    acc,
  input  logic [MEM_IF_WIDTH-1:0] ret_data,
  input  logic                    ret_valid,
  output logic [MEM_IF_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    pending,
  output logic                    err_sticky
);
  localparam int OW = $clog2(MAX_RD_OUTSTANDING + 1);
  logic [OW-1:0] outstanding;
  logic          ret;
  // a return with nothing in flight is dropped, even if a read is accepted the same cycle
  assign ret     = ret_valid & (outstanding != '0);
  assign full    = outstanding == OW'(MAX_RD_OUTSTANDING);
  assign pending = outstanding != '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      err_sticky  <= 1'b0;
    end else begin
      outstanding <= outstanding + OW'(acc) - OW'(ret);
      rd_valid    <= ret;
      rd_data     <= ret_data;
      err_sticky  <= err_sticky | (ret_valid & ~ret);
    end
  end
endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: write-priority arbiter sharing one DDR user port with bounded read starvation
module dram_port_arbiter
  import dram_if_pkg::*;
#(
  parameter int MEM_IF_WIDTH       = 128,
  parameter int ADX_WIDTH          = 27,
  parameter int WR_STREAK_MAX      = 8,
  parameter int MAX_RD_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dram_port_arbiter_if.master  bus,
  output logic                 busy,
  output logic                 err_sticky
);
  localparam int SW = $clog2(WR_STREAK_MAX + 1);
  arb_state_t              state, state_nxt;
  logic [SW-1:0]           streak;
  logic [ADX_WIDTH-1:0]    cap_addr;
  logic [MEM_IF_WIDTH-1:0] cap_data;
  logic                    cmd_done, data_done, full, pending;
  logic                    go_rd, go_wr, cmd_hs, data_hs;
  always_comb begin
    go_rd     = state == ST_IDLE & bus.rd_req & ~full & (streak == SW'(WR_STREAK_MAX) | ~bus.wr_req);
    go_wr     = state == ST_IDLE & ~go_rd & bus.wr_req;
    cmd_hs    = bus.app_en & bus.app_rdy;
    data_hs   = bus.app_wdf_wren & bus.app_wdf_rdy;
    state_nxt = go_rd ? ST_READ :
                go_wr ? ST_WRITE :
                ((state == ST_WRITE & cmd_done & data_done) | (state == ST_READ & bus.app_rdy)) ? ST_IDLE :
                state;
  end
  assign bus.wr_ack       = go_wr & ~reset;
  assign bus.rd_ack       = state == ST_READ & bus.app_rdy;
  assign bus.app_en       = (state == ST_WRITE & ~cmd_done) | state == ST_READ;
  assign bus.app_cmd      = state == ST_READ ? DDR_CMD_READ : DDR_CMD_WRITE;
  assign bus.app_addr     = cap_addr;
  assign bus.app_wdf_data = cap_data;
  assign bus.app_wdf_wren = state == ST_WRITE & ~data_done;
  assign bus.app_wdf_end  = bus.app_wdf_wren;
  assign busy             = state != ST_IDLE | pending;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      streak    <= '0;
      cap_addr  <= '0;
      cap_data  <= '0;
      cmd_done  <= 1'b0;
      data_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (go_rd) begin
        cap_addr <= bus.rd_addr;
        streak   <= '0;
      end
      if (go_wr) begin
        cap_addr  <= bus.wr_addr;
        cap_data  <= bus.wr_data;
        streak    <= ~bus.rd_req ? '0 : streak == SW'(WR_STREAK_MAX) ? streak : streak + SW'(1);
        cmd_done  <= 1'b0;
        data_done <= 1'b0;
      end
      if (state == ST_WRITE & cmd_hs) cmd_done <= 1'b1;
      if (data_hs) data_done <= 1'b1;
    end
  end
  dram_rd_tracker #(.MEM_IF_WIDTH(MEM_IF_WIDTH), .MAX_RD_OUTSTANDING(MAX_RD_OUTSTANDING)) u_trk (
    .clk       (clk),
    .reset     (reset),
    .acc       (bus.rd_ack),
    .ret_data  (bus.app_rd_data),
    .ret_valid (bus.app_rd_data_valid),
    .rd_data   (bus.rd_data),
    .rd_valid  (bus.rd_valid),
    .full      (full),
    .pending   (pending),
    .err_sticky(err_sticky)
  );
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: directed self-checking bench for dram_port_arbiter
module tb_dram_port_arbiter;
  localparam int W = 128;
  localparam int A = 27;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, err_sticky;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt;
  string gseq;
  logic [A-1:0] wq[$];
  logic [W-1:0] dq[$];
  int ackc[$];
  dram_port_arbiter_if #(.MEM_IF_WIDTH(W), .ADX_WIDTH(A)) bus ();
  dram_port_arbiter #(.MEM_IF_WIDTH(W), .ADX_WIDTH(A), .WR_STREAK_MAX(8), .MAX_RD_OUTSTANDING(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .err_sticky(err_sticky)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      gseq <= "";
      rd_cnt <= 0;
      wq.delete();
      dq.delete();
      ackc.delete();
    end else begin
      if (bus.wr_ack) begin
        gseq <= {gseq, "W"};
        ackc.push_back(cyc);
      end
      if (bus.rd_ack) begin
        gseq <= {gseq, "R"};
        rd_cnt <= rd_cnt + 1;
      end
      if (bus.app_en & bus.app_rdy & bus.app_cmd == 3'b000) wq.push_back(bus.app_addr);
      if (bus.app_wdf_wren & bus.app_wdf_rdy) dq.push_back(bus.app_wdf_data);
    end
  end
  task automatic chk(input string t, input bit bad);
    checks++;
    if (bad) begin
      errors++;
      $error("FAIL %s", t);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    bus.app_rd_data = '0; bus.app_rd_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic wr_chunk(input logic [A-1:0] a, input logic [W-1:0] d, input bit hold);
    int n = 0;
    bus.wr_addr = a; bus.wr_data = d; bus.wr_req = 1'b1;
    #1;
    while (!bus.wr_ack && n < 40) begin @(negedge clk); n++; end
    chk("wr_ack", bus.wr_ack !== 1'b1);
    @(posedge clk); #1;
    if (!hold) bus.wr_req = 1'b0;
  endtask
  task automatic rd_cmd(input logic [A-1:0] a, input bit ret_same, input logic [W-1:0] d);
    int n = 0;
    bus.rd_addr = a; bus.rd_req = 1'b1;
    #1;
    while (!bus.rd_ack && n < 40) begin @(negedge clk); n++; end
    chk("rd_ack", bus.rd_ack !== 1'b1);
    chk("rd_cmd_addr", bus.app_addr !== a);
    chk("rd_cmd_code", bus.app_cmd !== 3'b001);
    if (ret_same) begin bus.app_rd_data = d; bus.app_rd_data_valid = 1'b1; end
    @(posedge clk); #1;
    bus.rd_req = 1'b0; bus.app_rd_data_valid = 1'b0;
  endtask
  task automatic ret_pulse(input logic [W-1:0] d);
    bus.app_rd_data = d; bus.app_rd_data_valid = 1'b1;
    @(posedge clk); #1;
    bus.app_rd_data_valid = 1'b0;
  endtask
  initial begin
    string exp2 = "WWWWWWWWRWWWWWWWWR";
    int n;
    logic [W-1:0] d;
    do_reset();
    chk("rst_app_en", bus.app_en !== 1'b0);
    chk("rst_wren", bus.app_wdf_wren !== 1'b0);
    chk("rst_acks", {bus.wr_ack, bus.rd_ack, bus.rd_valid} !== 3'b000);
    chk("rst_busy", busy !== 1'b0);
    chk("rst_err", err_sticky !== 1'b0);
    chk("rst_addr", bus.app_addr !== 27'h0);
    chk("rst_rd_data", bus.rd_data !== 128'h0);
    for (int i = 0; i < 4; i++) begin
      d = {4{32'hA000_0000 + 32'(i)}};
      wr_chunk(A'(8 * i), d, i < 3);
    end
    repeat (4) @(posedge clk); #1;
    chk("t1_wr_cnt", wq.size() !== 4);
    chk("t1_data_cnt", dq.size() !== 4);
    for (int i = 0; i < 4; i++) begin
      d = {4{32'hA000_0000 + 32'(i)}};
      chk("t1_wr_addr", wq[i] !== A'(8 * i));
      chk("t1_wr_data", dq[i] !== d);
    end
    chk("t1_rate", ackc[3] - ackc[0] !== 9);
    chk("t1_idle", busy !== 1'b0);
    do_reset();
    bus.wr_addr = 27'h200; bus.wr_data = {4{32'h2222_2222}}; bus.wr_req = 1'b1;
    bus.rd_addr = 27'h300; bus.rd_req = 1'b1;
    n = 0;
    while (gseq.len() < 18 && n < 300) begin @(posedge clk); n++; end
    #1 bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    checks++;
    assert (gseq.substr(0, 17) == exp2) else begin
      errors++;
      $error("FAIL t2_grant_seq: observed %s expected %s", gseq, exp2);
    end
    do_reset();
    bus.app_rdy = 1'b0;
    wr_chunk(27'h100, {4{32'h3333_3333}}, 1'b0);
    chk("t3_en", bus.app_en !== 1'b1);
    chk("t3_wren", bus.app_wdf_wren !== 1'b1);
    chk("t3_wdf_end", bus.app_wdf_end !== 1'b1);
    @(posedge clk); #1;
    chk("t3_wren_done", bus.app_wdf_wren !== 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("t3_en_wait", bus.app_en !== 1'b1);
    bus.app_rdy = 1'b1;
    @(posedge clk); #1;
    chk("t3_en_done", bus.app_en !== 1'b0);
    chk("t3_busy_write", busy !== 1'b1);
    @(posedge clk); #1;
    chk("t3_idle", busy !== 1'b0);
    chk("t3_cmds", wq.size() !== 1);
    chk("t3_beats", dq.size() !== 1);
    chk("t3_addr", wq[0] !== 27'h100);
    do_reset();
    for (int i = 0; i < 4; i++) rd_cmd(A'(27'h40 + 8 * i), 1'b0, '0);
    bus.rd_addr = 27'h55; bus.rd_req = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("t4_rd_blocked", rd_cnt !== 4);
    chk("t4_busy", busy !== 1'b1);
    wr_chunk(27'h88, {4{32'h4444_4444}}, 1'b0);
    chk("t4_rd_still_blocked", rd_cnt !== 4);
    ret_pulse({4{32'h0BAD_F00D}});
    chk("t4_rd_valid", bus.rd_valid !== 1'b1);
    chk("t4_rd_data", bus.rd_data !== {4{32'h0BAD_F00D}});
    rd_cmd(27'h55, 1'b0, '0);
    chk("t4_rd_granted", rd_cnt !== 5);
    do_reset();
    rd_cmd(27'h10, 1'b0, '0);
    rd_cmd(27'h18, 1'b1, {4{32'h5555_AAAA}});
    chk("t5_rd_valid", bus.rd_valid !== 1'b1);
    chk("t5_rd_data", bus.rd_data !== {4{32'h5555_AAAA}});
    chk("t5_one_left", busy !== 1'b1);
    ret_pulse({4{32'h1234_5678}});
    chk("t5_rd_valid2", bus.rd_valid !== 1'b1);
    chk("t5_drained", busy !== 1'b0);
    chk("t5_no_err", err_sticky !== 1'b0);
    do_reset();
    rd_cmd(27'h20, 1'b0, '0);
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
    wr_chunk(27'h60, {4{32'h6666_6666}}, 1'b0);
    chk("t6_en_stuck", bus.app_en !== 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_en", bus.app_en !== 1'b0);
    chk("t6_rst_wren", bus.app_wdf_wren !== 1'b0);
    chk("t6_rst_busy", busy !== 1'b0);
    chk("t6_rst_err", err_sticky !== 1'b0);
    reset = 1'b0;
    ret_pulse({4{32'h7777_7777}});
    chk("t6_dropped", bus.rd_valid !== 1'b0);
    chk("t6_err", err_sticky !== 1'b1);
    repeat (2) @(posedge clk); #1;
    chk("t6_err_hold", err_sticky !== 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
